// File: rtl/seq_sdiv_20x8.sv
// Restoring radix-2 signed divider: DW-bit dividend / VW-bit divisor -> QW-bit saturated quotient, VW-bit remainder.
// Fixed 22-cycle accept-to-out_valid latency; result held while out_ready is low, no new accept until handshake.
module seq_sdiv_20x8 #(
   parameter int DW = 20,
   parameter int VW = 8,
   parameter int QW = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [QW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          ovf,
   output logic          dbz
);

   localparam int CW = $clog2(DW);
   localparam logic [DW-1:0] QPOS = DW'((1 << (QW-1)) - 1);
   localparam logic [DW-1:0] QNEG = DW'(1 << (QW-1));
   localparam logic [QW-1:0] QMAX = QPOS[QW-1:0];
   localparam logic [QW-1:0] QMIN = QNEG[QW-1:0];

   typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

   state_t        state_q;
   logic [DW-1:0] dvd_q;
   logic [VW-1:0] dvs_q;
   logic [VW-1:0] rem_q;
   logic [CW-1:0] cnt_q;
   logic          sgnq_q, sgnr_q, zdiv_q;
   logic          in_ready_q, out_valid_q, ovf_q, dbz_q;
   logic [QW-1:0] quotient_q;
   logic [VW-1:0] remainder_q;

   logic [VW:0]   rem_sh, diff;
   logic          ge;
   logic [VW-1:0] rem_d;
   logic [DW-1:0] dvd_d;
   logic [DW-1:0] dvd_abs;
   logic [VW-1:0] dvs_abs;
   logic [QW-1:0] q_lo, q_fix_d;
   logic [VW-1:0] r_fix_d;
   logic          ovf_fix_d;

   always_comb begin
      dvd_abs = dividend[DW-1] ? (~dividend + 1'b1) : dividend;
      dvs_abs = divisor[VW-1]  ? (~divisor + 1'b1)  : divisor;

      // dvd_q shifts dividend bits out at the top and quotient bits in at the bottom
      rem_sh = {rem_q, dvd_q[DW-1]};
      ge     = rem_sh >= {1'b0, dvs_q};
      diff   = rem_sh - {1'b0, dvs_q};
      rem_d  = ge ? diff[VW-1:0] : rem_sh[VW-1:0];
      dvd_d  = {dvd_q[DW-2:0], ge};

      q_lo      = dvd_q[QW-1:0];
      ovf_fix_d = 1'b0;
      if (zdiv_q) begin
         q_fix_d = sgnr_q ? QMIN : QMAX;
         r_fix_d = '0;
      end else begin
         r_fix_d = sgnr_q ? (~rem_q + 1'b1) : rem_q;
         if (!sgnq_q && dvd_q > QPOS) begin
            q_fix_d   = QMAX;
            ovf_fix_d = 1'b1;
         end else if (sgnq_q && dvd_q > QNEG) begin
            q_fix_d   = QMIN;
            ovf_fix_d = 1'b1;
         end else begin
            q_fix_d = sgnq_q ? (~q_lo + 1'b1) : q_lo;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         sgnq_q      <= 1'b0;
         sgnr_q      <= 1'b0;
         zdiv_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         ovf_q       <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  dvd_q      <= dvd_abs;
                  dvs_q      <= dvs_abs;
                  rem_q      <= '0;
                  cnt_q      <= CW'(DW-1);
                  sgnq_q     <= dividend[DW-1] ^ divisor[VW-1];
                  sgnr_q     <= dividend[DW-1];
                  zdiv_q     <= (divisor == '0);
                  in_ready_q <= 1'b0;
                  state_q    <= DIV;
               end
            end
            DIV: begin
               dvd_q <= dvd_d;
               rem_q <= rem_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) state_q <= FIX;
            end
            FIX: begin
               quotient_q  <= q_fix_d;
               remainder_q <= r_fix_d;
               ovf_q       <= ovf_fix_d;
               dbz_q       <= zdiv_q;
               state_q     <= DONE;
            end
            DONE: begin
               // first DONE cycle is a settle slot that gives the fixed 22-cycle latency
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign ovf       = ovf_q;
   assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_sdiv_20x8.sv
// Directed and randomized checks of seq_sdiv_20x8 against an integer-arithmetic reference.
module tb_seq_sdiv_20x8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [19:0] dividend = '0;
   logic [7:0]  divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [11:0] quotient;
   logic [7:0]  remainder;
   logic        ovf;
   logic        dbz;

   int n_cmp = 0;
   int n_bad = 0;

   seq_sdiv_20x8 dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .ovf(ovf), .dbz(dbz)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: truncating signed division with saturation to 12 bits.
   task automatic model(input int a, input int b, output logic [11:0] q,
                        output logic [7:0] r, output logic o, output logic z);
      int qf;
      o = 1'b0;
      z = 1'b0;
      if (b == 0) begin
         z = 1'b1;
         q = (a >= 0) ? 12'(2047) : 12'(-2048);
         r = 8'd0;
      end else begin
         qf = a / b;
         r  = 8'(a % b);
         if (qf > 2047) begin
            q = 12'(2047); o = 1'b1;
         end else if (qf < -2048) begin
            q = 12'(-2048); o = 1'b1;
         end else begin
            q = 12'(qf);
         end
      end
   endtask

   task automatic run(input string tag, input int a, input int b, input int hold);
      logic [11:0] eq;
      logic [7:0]  er;
      logic        eo, ez;
      model(a, b, eq, er, eo, ez);
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      dividend = 20'(a);
      divisor  = 8'(b);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         if (k == 5 && hold > 0) begin
            dividend = 20'd77;
            divisor  = 8'd1;
            in_valid = 1'b1;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (k == 21) check({tag, ".early"}, 32'(out_valid), 32'd0);
      end
      check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".quotient"}, 32'(quotient), 32'(eq));
      check({tag, ".remainder"}, 32'(remainder), 32'(er));
      check({tag, ".ovf"}, 32'(ovf), 32'(eo));
      check({tag, ".dbz"}, 32'(dbz), 32'(ez));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check({tag, ".hold_vld"}, 32'(out_valid), 32'd1);
         check({tag, ".hold_q"}, {20'd0, quotient}, 32'(eq));
         check({tag, ".hold_r"}, {24'd0, remainder}, 32'(er));
         check({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ".drop_vld"}, 32'(out_valid), 32'd0);
      check({tag, ".rdy_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [19:0] ra;
      logic [7:0]  rb;
      int a, b;
      #12;
      rst = 1'b0;
      @(negedge clk);
      check("rst.in_ready", 32'(in_ready), 32'd1);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.quotient", 32'(quotient), 32'd0);
      check("rst.remainder", 32'(remainder), 32'd0);
      check("rst.flags", {30'd0, ovf, dbz}, 32'd0);
      @(posedge clk); #1;

      run("t1", 1000, 7, 0);
      run("t2a", -1000, 7, 0);
      run("t2b", 1000, -7, 0);
      run("t3a", 100000, 3, 0);
      run("t3b", -524288, -1, 0);
      run("t4a", 5, 0, 0);
      run("t4b", -5, 0, 0);
      run("zero", 0, 9, 0);
      run("m128", -524288, -128, 0);
      run("bp", 12345, -45, 5);

      // asynchronous abort in the middle of the iteration phase
      dividend = 20'd50000;
      divisor  = 8'd3;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst = 1'b1;
      #1 check("abort.vld_in_rst", 32'(out_valid), 32'd0);
      #2 rst = 1'b0;
      #1 check("abort.out_valid", 32'(out_valid), 32'd0);
      check("abort.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check("abort.idle", 32'(in_ready), 32'd1);
      run("t6", 127, -128, 0);

      for (int i = 0; i < 24; i++) begin
         ra = 20'($urandom);
         if (i % 3 == 0) ra = 20'($signed(ra) >>> 8);
         rb = 8'($urandom);
         if (i % 7 == 3) rb = 8'd0;
         a = int'($signed(ra));
         b = int'($signed(rb));
         run($sformatf("rnd%0d", i), a, b, (i % 5 == 0) ? 2 : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_sdiv_20x8.md
Name: seq_sdiv_20x8

Overview:
- Multi-cycle signed integer divider. It is the inverse operation of the team's 12x8 signed multiplier datapath.
- Takes the 20-bit signed product-domain value and an 8-bit signed divisor. Returns a 12-bit signed quotient and an 8-bit signed remainder.
- Used in the CNN path for rescaling and normalisation after accumulation.
- Restoring radix-2 algorithm, one quotient bit per cycle, with valid/ready handshakes on both sides.

Parameters:
- DW, 20, dividend width (signed).
- VW, 8, divisor and remainder width (signed).
- QW, 12, quotient output width (signed, saturating). QW <= DW is required.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  dividend/divisor pair valid
- in_ready  output  1  block can accept a pair (high only in IDLE)
- dividend  input  DW  signed dividend
- divisor  input  VW  signed divisor
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  consumer accepts result
- quotient  output  QW  signed quotient, truncated toward zero, saturated
- remainder  output  VW  signed remainder; sign follows dividend
- ovf  output  1  quotient saturated
- dbz  output  1  divisor was zero

Behaviour:
- One clock domain. Reset is asynchronous and active-high on rst.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - quotient, remainder, ovf, dbz = 0.
  - Internal registers cleared.
- States: IDLE, DIV, FIX, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid && in_ready at a clock edge (E0), latch the operands:
    - |dividend| as a DW-bit unsigned value (2^19 must be representable).
    - |divisor| as a VW-bit unsigned value (128 must be representable).
    - Sign of the quotient = XOR of the operand signs; sign of the remainder = dividend sign; zero-divisor flag.
  - Partial remainder cleared, iteration counter = DW-1. Go to DIV.
- DIV:
  - Each cycle: shift the partial remainder left by one, bringing in the next dividend MSB.
  - Trial-subtract |divisor|. If non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
  - Counter decrements. After exactly DW iterations (edges E1..E20) go to FIX.
- FIX (one cycle, edge E21):
  - Apply signs: the quotient is negated if sign_q; the remainder is negated if the dividend was negative.
  - Compare the signed full-width quotient against the QW range [-2^(QW-1), 2^(QW-1)-1]. If out of range, clamp to the nearest bound and set ovf = 1.
  - remainder is the exact remainder of the unsaturated division, even when ovf = 1. |remainder| <= 127, so it always fits in VW bits.
  - Divide-by-zero: dbz = 1, ovf = 0, remainder = 0. quotient = 2^(QW-1)-1 if dividend >= 0, else -2^(QW-1).
  - Go to DONE.
- DONE:
  - out_valid = 1 starting from edge E22, so latency is fixed at 22 cycles from acceptance for every input, including divide-by-zero.
  - quotient, remainder, ovf and dbz are stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid drops and the state goes to IDLE.
  - in_ready rises the cycle after the handshake. There are no back-to-back accepts and no overlap.
- in_valid is ignored outside IDLE. Operand values are sampled only at the accept edge.
- rst asserted mid-operation (DIV, FIX or DONE) aborts immediately: the state returns to IDLE and all outputs take their reset values. The pending result is discarded.
- Dividend 0: quotient 0, remainder 0, ovf 0.
- Divisor -128: handled through its 128 magnitude; no special case.

Test Plan:
1. dividend = 1000, divisor = 7 -> quotient 142, remainder 6, ovf 0, dbz 0. out_valid rises exactly 22 cycles after the accept edge.
2. dividend = -1000, divisor = 7 -> quotient -142, remainder -6. dividend = 1000, divisor = -7 -> quotient -142, remainder 6.
3. dividend = 100000, divisor = 3 -> quotient 2047, ovf 1, remainder 1. dividend = -524288, divisor = -1 -> quotient 2047, ovf 1, remainder 0.
4. dividend = 5, divisor = 0 -> quotient 2047, remainder 0, dbz 1, ovf 0. dividend = -5, divisor = 0 -> quotient -2048, dbz 1. Latency is still 22 cycles in both cases.
5. Back-pressure: hold out_ready = 0 for 5 cycles after out_valid -> outputs stable and in_ready = 0 throughout. in_valid pulsed during DIV is ignored. Raising out_ready completes the handshake, and in_ready = 1 the next cycle.
6. Assert rst asynchronously at iteration 10 of DIV -> out_valid = 0 and in_ready = 1 immediately after release. A following 127 / -128 transaction gives quotient 0, remainder 127.
